// File: rtl/byte_mem_pkg.sv
// Shared definitions for the N-channel byte-memory arbiter:
// arbitration mode codes and small index helpers.
package byte_mem_pkg;

   localparam logic ARB_RR  = 1'b0;
   localparam logic ARB_FIX = 1'b1;
   localparam int   MAX_NCH = 8;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic logic [2:0] onehot_to_idx(input logic [MAX_NCH-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_NCH; i++)
         if (oh[i]) idx |= 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin / fixed-priority arbiter: combinational one-hot grant,
// registered search pointer advanced past each granted channel.
module rr_arb
   import byte_mem_pkg::*;
#(
   parameter int NCH = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           mode,
   input  logic [NCH-1:0] req,
   output logic [NCH-1:0] gnt
);

   localparam int PW = clog2(NCH);

   logic [PW-1:0] ptr;
   logic [PW:0]   idx;
   logic          found;
   logic [2:0]    gidx;

   // NOTE: every variable gets a default before the search loop, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      if (!reset) begin
         for (int i = 0; i < NCH; i++) begin
            if (mode == ARB_FIX) begin
               idx = (PW+1)'(i);
            end else begin
               idx = {1'b0, ptr} + (PW+1)'(i);
               if (idx >= (PW+1)'(NCH)) idx = idx - (PW+1)'(NCH);
            end
            if (!found && req[idx[PW-1:0]]) begin
               gnt[idx[PW-1:0]] = 1'b1;
               found            = 1'b1;
            end
         end
      end
   end

   assign gidx = onehot_to_idx(MAX_NCH'(gnt));

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (|gnt)
         ptr <= (gidx == 3'(NCH-1)) ? '0 : PW'(gidx + 3'd1);
   end

endmodule

// File: rtl/byte_mem_arb.sv
// N-channel client front end for a single-port byte memory: arbitration,
// registered command stage and a read-tag pipeline that steers returned data.
module byte_mem_arb
   import byte_mem_pkg::*;
#(
   parameter int NCH      = 2,
   parameter int AW       = 17,
   parameter int DW       = 8,
   parameter int RD_LAT   = 1,
   parameter int ARB_MODE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH*AW-1:0] req_ad,
   input  logic [NCH*DW-1:0] req_di,
   input  logic [NCH-1:0]    req_en,
   input  logic [NCH-1:0]    req_wr,
   output logic [NCH-1:0]    req_rdy,
   output logic [DW-1:0]     rsp_do,
   output logic [NCH-1:0]    rsp_en,
   output logic [AW-1:0]     m_addr,
   output logic [DW-1:0]     m_di,
   output logic              m_en,
   output logic              m_wr,
   input  logic [DW-1:0]     m_do
);

   localparam logic MODE = (ARB_MODE != 0) ? ARB_FIX : ARB_RR;

   logic [NCH-1:0] gnt;
   logic [AW-1:0]  sel_ad;
   logic [DW-1:0]  sel_di;
   logic           sel_wr;
   logic [NCH-1:0] m_ch;
   logic [NCH-1:0] tag [RD_LAT];

   rr_arb #(.NCH(NCH)) u_arb (
      .clk   (clk),
      .reset (reset),
      .mode  (MODE),
      .req   (req_en),
      .gnt   (gnt)
   );

   assign req_rdy = gnt;

   // AND-OR select of the granted channel; gnt is one-hot or zero.
   always_comb begin
      sel_ad = '0;
      sel_di = '0;
      sel_wr = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         sel_ad |= req_ad[i*AW +: AW] & {AW{gnt[i]}};
         sel_di |= req_di[i*DW +: DW] & {DW{gnt[i]}};
         sel_wr |= req_wr[i] & gnt[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m_en   <= 1'b0;
         m_wr   <= 1'b0;
         m_addr <= '0;
         m_di   <= '0;
         m_ch   <= '0;
      end else begin
         m_en <= |gnt;
         m_ch <= gnt;
         if (|gnt) begin
            m_addr <= sel_ad;
            m_di   <= sel_di;
            m_wr   <= sel_wr;
         end
      end
   end

   // NOTE: the tag pipeline must be reset because it qualifies rsp_en; the read data path needs no reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < RD_LAT; s++) tag[s] <= '0;
      end else begin
         tag[0] <= (m_en && !m_wr) ? m_ch : '0;
         for (int s = 1; s < RD_LAT; s++) tag[s] <= tag[s-1];
      end
   end

   assign rsp_en = tag[RD_LAT-1];
   assign rsp_do = m_do;

endmodule
